// File: rtl/memory_access_if.sv
// ============================================================================
// Interface : memory_writeback_if
// Signals carried between the EX/MEM, MEM and MEM/WB boundaries of the RV32 pipeline.
// Optional : MEM_ACCESS_MISALIGN_EN adds the misaligned flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface memory_writeback_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  WE;
  logic                  RE;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [31:0]           npc;
  logic                  cond;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] LMD;
  logic [31:0]           condpc;
`ifdef MEM_ACCESS_MISALIGN_EN
  logic                  misaligned;
`endif

  modport dut (
    input  WE,
    input  RE,
    input  address,
    input  write_data,
    input  npc,
    input  cond,
    output read_data,
    output LMD,
    output condpc
`ifdef MEM_ACCESS_MISALIGN_EN
    ,
    output misaligned
`endif
  );
endinterface

`default_nettype wire

// File: rtl/memory_access.sv
// ============================================================================
// Module   : memory_access
// RV32 MEM stage: word-organised data memory, LMD load register, next-PC select.
// Optional : MEM_ACCESS_MISALIGN_EN flags misaligned accesses and suppresses them.
// Revision : 1.0
// ============================================================================
`default_nettype none

module memory_access #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  memory_writeback_if.dut mem_if
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] lmd;
  logic [DATA_WIDTH-1:0] word;
  logic [ADDR_W-1:0]     idx;
  logic                  wr_en;
  logic                  rd_en;
  logic                  unused_addr;

  // Byte offset and bits above the memory span are dropped, so addresses wrap.
  assign idx         = mem_if.address[ADDR_W+1:2];
  assign unused_addr = ^{mem_if.address[31:ADDR_W+2], mem_if.address[1:0]};
  assign word        = mem[idx];

  generate
    if (1) begin : g_access_enable
`ifdef MEM_ACCESS_MISALIGN_EN
      logic mis;
      assign mis               = (mem_if.WE | mem_if.RE) & (mem_if.address[1:0] != 2'b00);
      assign mem_if.misaligned = mis;
      assign wr_en             = mem_if.WE & ~mis;
      assign rd_en             = mem_if.RE & ~mis;
`else
      assign wr_en = mem_if.WE;
      assign rd_en = mem_if.RE;
`endif
    end
  endgenerate

  // Whole array clears on reset so a store interrupted by reset is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= mem_if.write_data;
    end
  end

  // Samples the pre-edge word, giving read-before-write when WE and RE coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lmd <= '0;
    end else if (rd_en) begin
      lmd <= word;
    end
  end

  assign mem_if.read_data = rd_en ? word : '0;
  assign mem_if.LMD       = lmd;
  assign mem_if.condpc    = mem_if.cond ? mem_if.address : mem_if.npc;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// ============================================================================
// Module   : tb_memory_access
// Directed self-checking bench for memory_access (default build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_memory_access;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  memory_writeback_if #(.DATA_WIDTH(32)) bus ();

  memory_access #(
    .DEPTH      (256),
    .DATA_WIDTH (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; leaves time 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.WE         = we;
    bus.RE         = re;
    bus.address    = addr;
    bus.write_data = wd;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.npc  = 32'd0;
    bus.cond = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    step();
    check("reset_lmd", bus.LMD, 32'h0);
    bus.RE = 1'b1;
    #1;
    check("reset_read0", bus.read_data, 32'h0);
    rst_n = 1'b1;

    // Store then load
    drive(1'b1, 1'b0, 32'd0, 32'hF000_0000);
    step();
    drive(1'b0, 1'b1, 32'd0, 32'h0);
    #1;
    check("load_read_data", bus.read_data, 32'hF000_0000);
    step();
    check("load_lmd", bus.LMD, 32'hF000_0000);

    // Wrap and alignment
    drive(1'b1, 1'b0, 32'd40, 32'h1234_5678);
    step();
    drive(1'b0, 1'b1, 32'd42, 32'h0);
    #1;
    check("offset_read_data", bus.read_data, 32'h1234_5678);
    step();
    check("offset_lmd", bus.LMD, 32'h1234_5678);
    bus.address = 32'd40 + 32'd1024;
    #1;
    check("wrap_read_data", bus.read_data, 32'h1234_5678);
    bus.address = 32'h8000_0028;
    #1;
    check("upper_bits_read", bus.read_data, 32'h1234_5678);

    // Read-before-write
    drive(1'b1, 1'b0, 32'd4, 32'hAAAA_AAAA);
    step();
    drive(1'b1, 1'b1, 32'd4, 32'h5555_5555);
    #1;
    check("rbw_read_before", bus.read_data, 32'hAAAA_AAAA);
    step();
    check("rbw_lmd_old", bus.LMD, 32'hAAAA_AAAA);
    check("rbw_read_after", bus.read_data, 32'h5555_5555);
    drive(1'b0, 1'b1, 32'd4, 32'h0);
    step();
    check("rbw_lmd_new", bus.LMD, 32'h5555_5555);

    // Idle: LMD holds, read port gated off
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    step();
    check("idle_lmd_hold", bus.LMD, 32'h5555_5555);
    check("idle_read_zero", bus.read_data, 32'h0);
    bus.address = 32'd40;
    step();
    check("idle_no_write", bus.LMD, 32'h5555_5555);

    // Next-PC select
    bus.npc     = 32'd4;
    bus.address = 32'd40;
    bus.cond    = 1'b0;
    #1;
    check("condpc_seq", bus.condpc, 32'd4);
    bus.cond = 1'b1;
    #1;
    check("condpc_taken", bus.condpc, 32'd40);
    bus.cond = 1'b0;

    // Asynchronous reset between edges
    drive(1'b1, 1'b0, 32'd8, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 1'b1, 32'd8, 32'h0);
    step();
    check("pre_reset_lmd", bus.LMD, 32'hDEAD_BEEF);
    bus.RE = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_lmd_zero", bus.LMD, 32'h0);
    bus.cond    = 1'b1;
    bus.address = 32'd40;
    #1;
    check("condpc_in_reset", bus.condpc, 32'd40);
    bus.cond = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, 1'b1, 32'd8, 32'h0);
    #1;
    check("async_word_lost", bus.read_data, 32'h0);
    bus.address = 32'd0;
    #1;
    check("async_word0_lost", bus.read_data, 32'h0);

    // Reset held: store attempt ignored
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'd12, 32'h1111_1111);
    step();
    check("held_lmd_zero", bus.LMD, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'd12, 32'h0);
    #1;
    check("held_no_store", bus.read_data, 32'h0);

    // First edge after deassertion performs a normal store
    drive(1'b1, 1'b0, 32'd12, 32'h0BAD_F00D);
    step();
    drive(1'b0, 1'b1, 32'd12, 32'h0);
    step();
    check("post_reset_store", bus.LMD, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
